// File: rtl/fifo_access_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_arb_pkg: shared width and FSM encoding for the status FIFO arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int DATA_W = 9;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD      = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_CLR_OV  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_access_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_access_arbiter_if: requester handshakes plus the FIFO strobe/status bus.
// Rev 1.0
// ---------------------------------------------------------------------------
interface fifo_access_arbiter_if;
   import fifo_arb_pkg::*;

   logic              wr_req_a;
   logic              wr_req_b;
   logic [DATA_W-1:0] wr_data_a;
   logic [DATA_W-1:0] wr_data_b;
   logic              wr_ack_a;
   logic              wr_ack_b;
   logic              rd_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_ov;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_read_n;
   logic              fifo_write_n;
   logic              fifo_clear_ov_n;
   logic [DATA_W-1:0] fifo_data_in;
   logic              ov_flag;

   // master: the arbiter itself; slave: requesters and FIFO around it
   modport master (
      input  wr_req_a, wr_req_b, wr_data_a, wr_data_b, rd_req,
      input  fifo_full, fifo_empty, fifo_ov, fifo_data_out,
      output wr_ack_a, wr_ack_b, rd_data, rd_valid,
      output fifo_read_n, fifo_write_n, fifo_clear_ov_n, fifo_data_in, ov_flag
   );

   modport slave (
      output wr_req_a, wr_req_b, wr_data_a, wr_data_b, rd_req,
      output fifo_full, fifo_empty, fifo_ov, fifo_data_out,
      input  wr_ack_a, wr_ack_b, rd_data, rd_valid,
      input  fifo_read_n, fifo_write_n, fifo_clear_ov_n, fifo_data_in, ov_flag
   );

endinterface
`default_nettype wire

// File: rtl/fifo_access_arbiter_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2: two-way round-robin arbiter; pointer moves past the granted port.
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   // ptr_q = 0 favours port 0 (A) on a tie, 1 favours port 1 (B)
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) begin
         ptr_d = grant[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_access_arbiter: shares one status FIFO between writers A/B and a reader.
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_access_arbiter
   import fifo_arb_pkg::*;
#(
   parameter bit READ_PRIO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fifo_access_arbiter_if.master bus
);

   state_t            state_q;
   state_t            state_d;
   logic              win_b_q;
   logic              win_b_d;
   logic [DATA_W-1:0] data_in_q;
   logic [DATA_W-1:0] data_in_d;
   logic              ov_flag_q;
   logic              ov_flag_d;
   logic              rd_legal;
   logic              wr_legal;
   logic              advance;
   logic [1:0]        grant;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({bus.wr_req_b, bus.wr_req_a}),
      .advance (advance),
      .grant   (grant)
   );

   // Every operation returns to IDLE so FIFO flags are always sampled fresh.
   always_comb begin
      state_d   = state_q;
      win_b_d   = win_b_q;
      data_in_d = data_in_q;
      ov_flag_d = ov_flag_q;
      advance   = 1'b0;
      rd_legal  = bus.rd_req & ~bus.fifo_empty;
      wr_legal  = (bus.wr_req_a | bus.wr_req_b) & ~bus.fifo_full;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.fifo_ov) begin
               state_d = ST_CLR_OV;
            end else if (rd_legal && (READ_PRIO || !wr_legal)) begin
               state_d = ST_RD;
            end else if (wr_legal) begin
               state_d   = ST_WR;
               advance   = 1'b1;
               win_b_d   = grant[1];
               data_in_d = grant[0] ? bus.wr_data_a : bus.wr_data_b;
            end
         end
         ST_WR:      state_d = ST_IDLE;
         ST_RD:      state_d = ST_RD_WAIT;
         ST_RD_WAIT: state_d = ST_IDLE;
         ST_CLR_OV: begin
            state_d   = ST_IDLE;
            ov_flag_d = 1'b1;
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         win_b_q   <= 1'b0;
         data_in_q <= '0;
         ov_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_b_q   <= win_b_d;
         data_in_q <= data_in_d;
         ov_flag_q <= ov_flag_d;
      end
   end

   // Strobes decode registered state only, so reset releases them at once.
   assign bus.fifo_write_n    = (state_q != ST_WR);
   assign bus.fifo_read_n     = (state_q != ST_RD);
   assign bus.fifo_clear_ov_n = (state_q != ST_CLR_OV);
   assign bus.wr_ack_a        = (state_q == ST_WR) & ~win_b_q;
   assign bus.wr_ack_b        = (state_q == ST_WR) & win_b_q;
   assign bus.rd_valid        = (state_q == ST_RD_WAIT);
   assign bus.rd_data         = (state_q == ST_RD_WAIT) ? bus.fifo_data_out : '0;
   assign bus.fifo_data_in    = data_in_q;
   assign bus.ov_flag         = ov_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_access_arbiter: directed boundary cases, then random traffic vs a FIFO model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_access_arbiter;
   import fifo_arb_pkg::*;

   localparam bit READ_PRIO = 1'b1;
   localparam int K_NONE = 0, K_WRA = 1, K_WRB = 2, K_RD = 3, K_RDV = 4, K_CLR = 5, K_BAD = 6;
   localparam int NEVER = 32'h7fff_ffff;

   typedef struct {
      int                cyc;
      int                kind;
      logic [DATA_W-1:0] data;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fifo_access_arbiter_if bus ();

   fifo_access_arbiter #(.READ_PRIO(READ_PRIO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int                n_cmp   = 0;
   int                n_err   = 0;
   int                cyc     = 0;
   int                free_at = 1;
   int                ov_at   = NEVER;
   bit                turn    = 1'b0;
   bit                sb_en   = 1'b0;
   ev_t               exp_q[$];
   logic [DATA_W-1:0] fq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int obs_kind();
      logic [5:0] v;
      v = {~bus.fifo_write_n, bus.wr_ack_a, bus.wr_ack_b,
           ~bus.fifo_read_n, bus.rd_valid, ~bus.fifo_clear_ov_n};
      case (v)
         6'b110000: return K_WRA;
         6'b101000: return K_WRB;
         6'b000100: return K_RD;
         6'b000010: return K_RDV;
         6'b000001: return K_CLR;
         6'b000000: return K_NONE;
         default:   return K_BAD;
      endcase
   endfunction

   task automatic idle_chk(input string name);
      chk({name, "_strobes"}, 32'(obs_kind()), 32'(K_NONE));
      chk({name, "_data_in"}, 32'(bus.fifo_data_in), 32'd0);
      chk({name, "_ov_flag"}, 32'(bus.ov_flag), 32'd0);
   endtask

   // Reference: when the arbiter is free, apply the priority rules and schedule events.
   task automatic model_decide();
      bit wa, wb, win;
      wa = bus.wr_req_a && !bus.fifo_full;
      wb = bus.wr_req_b && !bus.fifo_full;
      if (bus.fifo_ov) begin
         exp_q.push_back(ev_t'{cyc, K_CLR, {DATA_W{1'b0}}});
         if (ov_at == NEVER) ov_at = cyc + 1;
         free_at = cyc + 2;
      end else if (bus.rd_req && !bus.fifo_empty && (READ_PRIO || !(wa || wb))) begin
         exp_q.push_back(ev_t'{cyc, K_RD, {DATA_W{1'b0}}});
         exp_q.push_back(ev_t'{cyc + 1, K_RDV, fq[0]});
         free_at = cyc + 3;
      end else if (wa || wb) begin
         win = (wa && wb) ? turn : wb;
         exp_q.push_back(ev_t'{cyc, win ? K_WRB : K_WRA, win ? bus.wr_data_b : bus.wr_data_a});
         turn    = !win;
         free_at = cyc + 2;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT shows a strobe, ack or valid.
   initial begin : monitor
      ev_t               e;
      int                k;
      logic [DATA_W-1:0] d;
      forever begin
         @(negedge clk);
         if (sb_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               n_cmp++;
               n_err++;
               $display("FAIL missed_event: got nothing at cyc=%0d, expected kind=%0d data=%h",
                        e.cyc, e.kind, e.data);
            end
            k = obs_kind();
            d = (k == K_WRA || k == K_WRB) ? bus.fifo_data_in :
                (k == K_RDV) ? bus.rd_data : {DATA_W{1'b0}};
            if (k != K_NONE) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL event: got cyc=%0d kind=%0d data=%h, expected none", cyc, k, d);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.kind != k || e.data !== d) begin
                     n_err++;
                     $display("FAIL event: got cyc=%0d kind=%0d data=%h, expected cyc=%0d kind=%0d data=%h",
                              cyc, k, d, e.cyc, e.kind, e.data);
                  end
               end
            end
            chk("ov_flag", 32'(bus.ov_flag), 32'(cyc >= ov_at));
         end
      end
   end

   initial begin : driver
      bit                c_w, c_r, c_clr, c_aa, c_ab, c_rv, heavy;
      logic [DATA_W-1:0] c_din;
      int                bad;

      bus.wr_req_a = 1'b0;  bus.wr_req_b = 1'b0;
      bus.wr_data_a = '0;   bus.wr_data_b = '0;
      bus.rd_req = 1'b0;    bus.fifo_full = 1'b0;
      bus.fifo_empty = 1'b1; bus.fifo_ov = 1'b0;
      bus.fifo_data_out = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_chk("reset_in");
      rst_n = 1'b1;
      @(negedge clk);
      idle_chk("reset_out");

      // contention: both held, alternating acks, one write every 2 cycles
      bus.wr_req_a = 1'b1; bus.wr_data_a = 9'h011;
      bus.wr_req_b = 1'b1; bus.wr_data_b = 9'h022;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); @(negedge clk);
         chk("contend_ack_a", 32'(bus.wr_ack_a), 32'(i % 4 == 0));
         chk("contend_ack_b", 32'(bus.wr_ack_b), 32'(i % 4 == 2));
      end
      bus.wr_req_a = 1'b0; bus.wr_req_b = 1'b0;
      @(negedge clk);

      // single write from A
      bus.wr_req_a = 1'b1; bus.wr_data_a = 9'h1A5;
      @(posedge clk); @(negedge clk);
      chk("single_write_n", 32'(bus.fifo_write_n), 32'd0);
      chk("single_data_in", 32'(bus.fifo_data_in), 32'h1A5);
      chk("single_ack_a", 32'(bus.wr_ack_a), 32'd1);
      chk("single_ack_b", 32'(bus.wr_ack_b), 32'd0);
      bus.wr_req_a = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("single_write_n_end", 32'(bus.fifo_write_n), 32'd1);
      chk("single_ack_a_end", 32'(bus.wr_ack_a), 32'd0);

      // reset mid-write releases the strobe without waiting for a clock
      bus.wr_req_b = 1'b1; bus.wr_data_b = 9'h055;
      @(posedge clk); #2;
      chk("midwr_write_n_before", 32'(bus.fifo_write_n), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midwr_write_n_async", 32'(bus.fifo_write_n), 32'd1);
      chk("midwr_ack_b", 32'(bus.wr_ack_b), 32'd0);
      bus.wr_req_b = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_chk("midwr_after");

      // full: request held with no strobe, then issues once full drops
      bus.fifo_full = 1'b1; bus.wr_req_b = 1'b1; bus.wr_data_b = 9'h0C3;
      bad = 0;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         if (obs_kind() != K_NONE) bad++;
      end
      chk("full_no_activity", 32'(bad), 32'd0);
      bus.fifo_full = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("full_release_write_n", 32'(bus.fifo_write_n), 32'd0);
      chk("full_release_ack_b", 32'(bus.wr_ack_b), 32'd1);
      chk("full_release_data", 32'(bus.fifo_data_in), 32'h0C3);
      bus.wr_req_b = 1'b0;
      @(posedge clk); @(negedge clk);

      // read beats a simultaneous write
      bus.fifo_empty = 1'b0; bus.rd_req = 1'b1;
      bus.wr_req_a = 1'b1; bus.wr_data_a = 9'h111;
      @(posedge clk); @(negedge clk);
      chk("read_read_n", 32'(bus.fifo_read_n), 32'd0);
      chk("read_write_n", 32'(bus.fifo_write_n), 32'd1);
      @(posedge clk); #1;
      bus.fifo_data_out = 9'h0F3;
      @(negedge clk);
      chk("read_valid", 32'(bus.rd_valid), 32'd1);
      chk("read_data", 32'(bus.rd_data), 32'h0F3);
      bus.rd_req = 1'b0; bus.fifo_empty = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("read_then_write_ack_a", 32'(bus.wr_ack_a), 32'd1);
      bus.wr_req_a = 1'b0;
      @(posedge clk); @(negedge clk);

      // overflow clear and sticky flag
      bus.fifo_ov = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("ov_clear_n", 32'(bus.fifo_clear_ov_n), 32'd0);
      chk("ov_flag_early", 32'(bus.ov_flag), 32'd0);
      bus.fifo_ov = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ov_clear_n_end", 32'(bus.fifo_clear_ov_n), 32'd1);
      chk("ov_flag_set", 32'(bus.ov_flag), 32'd1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("ov_flag_sticky", 32'(bus.ov_flag), 32'd1);

      // random traffic against a 16-deep FIFO model
      rst_n = 1'b0;
      bus.fifo_data_out = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_chk("rand_reset");
      cyc = 0; free_at = 1; turn = 1'b0; ov_at = NEVER;
      {c_w, c_r, c_clr, c_aa, c_ab, c_rv} = '0;
      c_din = '0;
      sb_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         cyc++;
         if (cyc >= free_at) model_decide();
         #1;
         if (c_w && fq.size() < 16) fq.push_back(c_din);
         if (c_r && fq.size() > 0) bus.fifo_data_out = fq.pop_front();
         if (c_clr) bus.fifo_ov = 1'b0;
         if (c_aa) bus.wr_req_a = 1'b0;
         if (c_ab) bus.wr_req_b = 1'b0;
         if (c_rv) bus.rd_req = 1'b0;
         heavy = ((i / 400) % 2) == 0;
         if (i < 2950) begin
            if (!bus.wr_req_a && !c_aa && $urandom_range(0, heavy ? 1 : 7) == 0) begin
               bus.wr_req_a = 1'b1; bus.wr_data_a = DATA_W'($urandom);
            end
            if (!bus.wr_req_b && !c_ab && $urandom_range(0, heavy ? 1 : 7) == 0) begin
               bus.wr_req_b = 1'b1; bus.wr_data_b = DATA_W'($urandom);
            end
            if (!bus.rd_req && !c_rv && $urandom_range(0, heavy ? 7 : 1) == 0) bus.rd_req = 1'b1;
            if (!bus.fifo_ov && !c_clr && $urandom_range(0, 59) == 0) bus.fifo_ov = 1'b1;
         end
         bus.fifo_full  = (fq.size() == 16);
         bus.fifo_empty = (fq.size() == 0);
         @(negedge clk);
         c_w   = !bus.fifo_write_n;
         c_din = bus.fifo_data_in;
         c_r   = !bus.fifo_read_n;
         c_clr = !bus.fifo_clear_ov_n;
         c_aa  = bus.wr_ack_a;
         c_ab  = bus.wr_ack_b;
         c_rv  = bus.rd_valid;
      end
      @(posedge clk);
      sb_en = 1'b0;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
